encoder16to4_design: RTL and testbench

ENCODER16TO4_DESIGN -- requirements
Module: encoder16to4_design

---
 rtl/encoder16to4_design.sv | 81 ++++++++
 tb/tb_encoder16to4_design.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/encoder16to4_design.sv
// encoder16to4_design
// Registered 16-to-4 priority encoder. The priority direction on multi-hot
// input is chosen by MSB_PRIORITY. Also flags "any line active" (valid) and
// "more than one line active" (err). One clock of latency, and the outputs
// come straight from flops.
module encoder16to4_design #(
  parameter int MSB_PRIORITY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] d,
  output logic [3:0]  y,
  output logic        valid,
  output logic        err
);

  localparam int DATA_W = 16;
  localparam int IDX_W  = 4;

  // Index of the highest set bit. Returns 0 for an all-zero vector.
  function automatic logic [IDX_W-1:0] f_enc_msb(input logic [DATA_W-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // Index of the lowest set bit. Returns 0 for an all-zero vector.
  function automatic logic [IDX_W-1:0] f_enc_lsb(input logic [DATA_W-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // Clearing the lowest set bit leaves something behind only if two or more
  // bits were set.
  function automatic logic f_multi_hot(input logic [DATA_W-1:0] v);
    return (v & (v - DATA_W'(1))) != '0;
  endfunction

  logic [IDX_W-1:0] w_y_p0;
  logic             w_any_p0;
  logic             w_multi_p0;

  logic [IDX_W-1:0] r_y_p1;
  logic             r_valid_p1;
  logic             r_err_p1;

  // ---- stage p0: combinational encode of the incoming request vector ----
  // Select the priority direction, then derive the activity flags.
  always_comb begin
    w_y_p0     = (MSB_PRIORITY != 0) ? f_enc_msb(d) : f_enc_lsb(d);
    w_any_p0   = |d;
    w_multi_p0 = f_multi_hot(d);
  end

  // ---- stage p1: output registers ----
  // Reset wins over enable. Otherwise capture on en and hold when en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y_p1     <= '0;
      r_valid_p1 <= 1'b0;
      r_err_p1   <= 1'b0;
    end else if (en) begin
      r_y_p1     <= w_y_p0;
      r_valid_p1 <= w_any_p0;
      r_err_p1   <= w_multi_p0;
    end
  end

  assign y     = r_y_p1;
  assign valid = r_valid_p1;
  assign err   = r_err_p1;

endmodule

// File: tb/tb_encoder16to4_design.sv
// Bench for encoder16to4_design. Both priority settings are instantiated
// side by side and share the same stimulus. A behavioural model predicts
// the registered outputs from scanned bit positions and a popcount.
module tb_encoder16to4_design;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] d;
  logic [3:0]  y1, y0;
  logic        v1, v0, e1, e0;

  int checks = 0;
  int errors = 0;

  encoder16to4_design #(.MSB_PRIORITY(1)) u_msb (
    .clk(clk), .rst(rst), .en(en), .d(d), .y(y1), .valid(v1), .err(e1));
  encoder16to4_design #(.MSB_PRIORITY(0)) u_lsb (
    .clk(clk), .rst(rst), .en(en), .d(d), .y(y0), .valid(v0), .err(e0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  bit       known = 1'b0;
  int       m_y_msb, m_y_lsb;
  bit       m_valid, m_err;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Model: scan the sampled vector for its lowest and highest active lines.
  always @(posedge clk) begin
    if (rst) begin
      m_y_msb = 0; m_y_lsb = 0; m_valid = 0; m_err = 0;
      known   = 1'b1;
    end else if (en) begin
      int hi, lo, cnt;
      hi = -1; lo = -1; cnt = 0;
      for (int i = 0; i < 16; i++) begin
        if (d[i]) begin
          if (lo < 0) lo = i;
          hi = i;
          cnt++;
        end
      end
      m_valid = (cnt > 0);
      m_err   = (cnt > 1);
      m_y_msb = (cnt > 0) ? hi : 0;
      m_y_lsb = (cnt > 0) ? lo : 0;
    end
  end

  // Compare both DUTs with the model on every falling edge once a reset has
  // been seen.
  always @(negedge clk) begin
    if (known) begin
      chk("cmp_msb_y",   16'(y1), 16'(m_y_msb));
      chk("cmp_msb_vld", 16'(v1), 16'(m_valid));
      chk("cmp_msb_err", 16'(e1), 16'(m_err));
      chk("cmp_lsb_y",   16'(y0), 16'(m_y_lsb));
      chk("cmp_lsb_vld", 16'(v0), 16'(m_valid));
      chk("cmp_lsb_err", 16'(e0), 16'(m_err));
    end
  end

  // Drive one cycle of inputs. The task returns just after the sampling
  // edge, so the registered result is already visible.
  task automatic cyc(input logic r, input logic e, input logic [15:0] dv);
    @(negedge clk);
    #1;
    rst = r; en = e; d = dv;
    @(posedge clk);
    #1;
  endtask

  // Literal expectation for both instances.
  task automatic lit(input string name, input int ey1, input int ey0,
                     input bit ev, input bit ee);
    chk({name, "_y_msb"}, 16'(y1), 16'(ey1));
    chk({name, "_y_lsb"}, 16'(y0), 16'(ey0));
    chk({name, "_vld_msb"}, 16'(v1), 16'(ev));
    chk({name, "_vld_lsb"}, 16'(v0), 16'(ev));
    chk({name, "_err_msb"}, 16'(e1), 16'(ee));
    chk({name, "_err_lsb"}, 16'(e0), 16'(ee));
  endtask

  initial begin
    logic [15:0] dv;
    rst = 1'b0; en = 1'b0; d = '0;

    // Reset held for two cycles while a full vector is presented
    cyc(1'b1, 1'b1, 16'hFFFF); lit("rst1", 0, 0, 0, 0);
    cyc(1'b1, 1'b1, 16'hFFFF); lit("rst2", 0, 0, 0, 0);

    // One-hot sweep
    cyc(1'b0, 1'b1, 16'h0000); lit("zero", 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      dv = 16'h0001 << i;
      cyc(1'b0, 1'b1, dv);
      lit($sformatf("onehot%0d", i), i, i, 1, 0);
    end

    // Multi-hot priority, plus pinning the model itself
    cyc(1'b0, 1'b1, 16'h0101); lit("prio0101", 8, 0, 1, 1);
    chk("model_msb_0101", 16'(m_y_msb), 16'd8);
    chk("model_lsb_0101", 16'(m_y_lsb), 16'd0);

    // Enable hold
    cyc(1'b0, 1'b1, 16'h0020); lit("load20", 5, 5, 1, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 16'h4000);
      lit($sformatf("hold%0d", k), 5, 5, 1, 0);
    end

    // Reset in the middle of a stream
    cyc(1'b0, 1'b1, 16'h8000); lit("top", 15, 15, 1, 0);
    cyc(1'b1, 1'b1, 16'h0004); lit("midrst", 0, 0, 0, 0);
    cyc(1'b0, 1'b1, 16'h0004); lit("postrst", 2, 2, 1, 0);

    // Zero after valid
    cyc(1'b0, 1'b1, 16'h0200); lit("bit9", 9, 9, 1, 0);
    cyc(1'b0, 1'b1, 16'h0000); lit("zero2", 0, 0, 0, 0);

    // All lines active
    cyc(1'b0, 1'b1, 16'hFFFF); lit("allhot", 15, 0, 1, 1);
    chk("model_err_ffff", 16'(m_err), 16'd1);

    // Randomised traffic
    for (int n = 0; n < 500; n++) begin
      logic r, e;
      r = ($urandom_range(0, 31) == 0);
      e = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 4))
        0: dv = 16'h0000;
        1: dv = 16'h0001 << $urandom_range(0, 15);
        2: dv = 16'hFFFF;
        3: dv = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
        default: dv = 16'($urandom);
      endcase
      cyc(r, e, dv);
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
